router_1xn: RTL and testbench
=============================

# router_1xn

Parametrised successor to the 1x3 router top level. It accepts one byte-serial packet stream and steers each packet into one of NUM_PORTS output FIFOs, selected by the address field of the packet header. Beyond the 1x3 generation it adds:
- a configurable port count, FIFO depth and read timeout;
- dropping of packets whose address has no port, instead of hanging;
- per-port read-timeout flush;
- a registered parity error flag and a drop pulse.

## Interface
- NUM_PORTS, 3: output channels, legal 1..4.
- FIFO_DEPTH, 16: words per output FIFO, power of 2, at least 4.
- TIMEOUT, 30: cycles that valid_out[i] may stay high without read_enb[i] before FIFO i is flushed.
- clock  in  1: single clock, rising edge.
- resetn  in  1: asynchronous active-low reset.
- pkt_valid  in  1: high from the header byte through the last payload byte; low on the parity byte.
- data_in  in  8: packet byte.
- read_enb  in  NUM_PORTS: per-port read request.
- data_out  out  8*NUM_PORTS: port i uses bits [8i+7:8i].
- valid_out  out  NUM_PORTS: FIFO i is non-empty.
- busy  out  1: source must hold data_in and pkt_valid while this is high.
- error  out  1: parity mismatch on the last completed packet.
- dropped  out  1: one-cycle pulse when a packet is discarded.

## Operation
- Packet format:
  - header = {len[7:2], addr[1:0]};
  - then len payload bytes, len from 1 to 63;
  - then the parity byte, equal to the XOR of the header and all payload bytes.
- dest is the addr field latched when the header is accepted.
- Controller FSM states and transitions:
  - IDLE, busy=0. On pkt_valid=1, latch the header, clear error, seed the running parity with the header. Next state: DROP if addr>=NUM_PORTS; else WAIT_EMPTY if valid_out[dest]=1; else LOAD_HDR.
  - WAIT_EMPTY, busy=1. Go to LOAD_HDR once FIFO dest is empty.
  - LOAD_HDR, busy=1. Write the header into FIFO dest, then go to LOAD_DATA.
  - LOAD_DATA, busy=0.
    - pkt_valid=1 and FIFO not full: write data_in and XOR it into the running parity.
    - pkt_valid=0: data_in is the parity byte. Write it, compare it, go to CHECK.
    - FIFO full: capture data_in and an is_parity flag into the hold register, go to FULL_WAIT.
  - FULL_WAIT, busy=1. When the FIFO is not full, write the hold register. Go to CHECK if is_parity is set, else LOAD_DATA.
  - CHECK, busy=1, one cycle. Set error if the received parity differs from the computed parity. Go to IDLE.
  - DROP, busy=0. Discard bytes until the pkt_valid=0 byte, pulse dropped in that cycle, go to IDLE.
- Output FIFO behaviour:
  - data_out is registered. A read with read_enb[i]=1 and FIFO not empty updates data_out on the next edge.
  - data_out holds its value otherwise.
- Timeout flush:
  - Per-port counter increments while valid_out[i]=1 and read_enb[i]=0, and clears on any read or when the FIFO is empty.
  - When the counter reaches TIMEOUT, assert soft_reset[i] for one cycle. This empties FIFO i and clears its counter.
  - If soft_reset[dest] fires while the FSM is in WAIT_EMPTY, LOAD_HDR, LOAD_DATA or FULL_WAIT: go to DROP if pkt_valid=1, else go to IDLE. The remaining bytes are discarded; dropped pulses.

## Timing
- Reset values: every data_out = 0, valid_out = 0, busy = 0, error = 0, dropped = 0. FSM goes to IDLE, FIFO pointers and counters clear.
- busy is decoded combinationally from the state.
- valid_out is registered: it goes high 1 cycle after the first write into an empty FIFO.
- A header accepted at cycle t with FIFO dest empty:
  - header written at t+1;
  - first payload byte accepted at t+2;
  - error valid 1 cycle after the parity byte is accepted (the CHECK cycle), held until the next header.
- A write into a full FIFO never occurs.
- Simultaneous read and write:
  - on a full FIFO: the read proceeds; the write is deferred through FULL_WAIT.
  - on an empty FIFO: the write proceeds; the read is ignored.
- soft_reset has priority over a same-cycle write or read on that FIFO.
- Pointers use log2(FIFO_DEPTH)+1 bits. Wrap-around is via the MSB; full and empty are compared from the pointers.

## Structure
- Package router_pkg holds:
  - the state enum (IDLE, WAIT_EMPTY, LOAD_HDR, LOAD_DATA, FULL_WAIT, CHECK, DROP);
  - the header field positions (ADDR_LSB=0, ADDR_W=2, LEN_LSB=2).
- Sub-module router_fifo_n: one FIFO plus its timeout counter, generated NUM_PORTS times.
- The FSM, hold register and parity logic live in router_1xn.

## Test plan
- NUM_PORTS=3: header 8'h0D (len 3, addr 1), payload 11,22,33, correct parity, read_enb[1] pulsed. Response: data_out[15:8] = 0D,11,22,33,parity; error=0; FIFO 0 and 2 untouched.
- Same packet with the parity byte XORed with 8'h01. Response: error=1 in the CHECK cycle, held until the next header.
- Header 8'h07 (addr 3, NUM_PORTS=3), len 1. Response: no valid_out rises; dropped pulses on the parity cycle; busy stays 0.
- FIFO_DEPTH=4, len 6, no reads. Response: busy rises after 4 writes. After read_enb[0] drains the FIFO, all 8 bytes are delivered in order with no loss.
- valid_out[2]=1 with read_enb[2]=0 for 30 cycles. Response: FIFO 2 is flushed, valid_out[2]=0 on the next cycle. Repeating this mid-packet sends the FSM to DROP.
- resetn asserted mid-packet in LOAD_DATA. Response: all outputs are 0 immediately; after release, a new header in IDLE is accepted normally.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared FSM state encoding and packet header field layout for router_1xn.
package router_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD_HDR, LOAD_DATA, FULL_WAIT, CHECK, DROP} state_t;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 2;
  localparam int LEN_LSB = 2;
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] h);
    return h[ADDR_LSB +: ADDR_W];
  endfunction
endpackage

// File: rtl/router_fifo_n.sv
// router_fifo_n: one output FIFO with registered read data and a read-timeout flush.
module router_fifo_n #(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       write,
  input  logic [7:0] din,
  input  logic       read,
  output logic [7:0] dout,
  output logic       valid,
  output logic       full,
  output logic       soft_reset
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic do_wr, do_rd;
  assign valid = wptr != rptr;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign do_wr = write && !full;
  assign do_rd = read && valid;
  // fires on the TIMEOUT-th consecutive unread cycle, so valid drops the cycle after
  assign soft_reset = valid && !read && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      dout <= '0;
    end else if (soft_reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr[AW-1:0]];
      end
      cnt <= (!valid || read) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/router_1xn.sv
// router_1xn: steers byte-serial packets into NUM_PORTS output FIFOs by header address,
// checking parity and dropping packets that have no port or whose FIFO times out.
module router_1xn
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   pkt_valid,
  input  logic [7:0]             data_in,
  input  logic [NUM_PORTS-1:0]   read_enb,
  output logic [8*NUM_PORTS-1:0] data_out,
  output logic [NUM_PORTS-1:0]   valid_out,
  output logic                   busy,
  output logic                   error,
  output logic                   dropped
);
  localparam int NA = 1 << ADDR_W;
  state_t state, next;
  logic [ADDR_W-1:0] dest, in_addr;
  logic [7:0] hdr, parity, hold, wdata;
  logic hold_par, wr, abort, addr_bad;
  logic [NUM_PORTS-1:0] full, soft_reset;
  logic [NA-1:0] valid4, full4, soft4;
  assign in_addr = hdr_addr(data_in);
  assign addr_bad = int'(in_addr) >= NUM_PORTS;
  assign valid4 = NA'(valid_out);
  assign full4 = NA'(full);
  assign soft4 = NA'(soft_reset);
  assign abort = soft4[dest] && state inside {WAIT_EMPTY, LOAD_HDR, LOAD_DATA, FULL_WAIT};
  assign busy = state inside {WAIT_EMPTY, LOAD_HDR, FULL_WAIT, CHECK};
  assign dropped = !pkt_valid && (state == DROP || abort);
  always_comb begin
    next = state;
    wr = 1'b0;
    wdata = data_in;
    case (state)
      IDLE:       if (pkt_valid) next = addr_bad ? DROP : valid4[in_addr] ? WAIT_EMPTY : LOAD_HDR;
      WAIT_EMPTY: if (!valid4[dest]) next = LOAD_HDR;
      LOAD_HDR: begin
        wr = 1'b1;
        wdata = hdr;
        next = LOAD_DATA;
      end
      LOAD_DATA: begin
        wr = !full4[dest];
        next = full4[dest] ? FULL_WAIT : pkt_valid ? LOAD_DATA : CHECK;
      end
      FULL_WAIT: begin
        wr = !full4[dest];
        wdata = hold;
        if (!full4[dest]) next = hold_par ? CHECK : LOAD_DATA;
      end
      CHECK:      next = IDLE;
      DROP:       if (!pkt_valid) next = IDLE;
      default:    next = IDLE;
    endcase
    if (abort) next = pkt_valid ? DROP : IDLE;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      dest <= '0;
      hdr <= '0;
      parity <= '0;
      hold <= '0;
      hold_par <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && pkt_valid) begin
        hdr <= data_in;
        dest <= in_addr;
        parity <= data_in;
        error <= 1'b0;
      end
      if (state == LOAD_DATA && !abort) begin
        if (pkt_valid) parity <= parity ^ data_in;
        if (full4[dest]) begin
          hold <= data_in;
          hold_par <= !pkt_valid;
        end else if (!pkt_valid) error <= data_in != parity;
      end
      if (state == FULL_WAIT && !abort && !full4[dest] && hold_par) error <= hold != parity;
    end
  end
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_fifo_n #(.DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) u_fifo (
      .clock(clock),
      .resetn(resetn),
      .write(wr && dest == ADDR_W'(i)),
      .din(wdata),
      .read(read_enb[i]),
      .dout(data_out[8*i +: 8]),
      .valid(valid_out[i]),
      .full(full[i]),
      .soft_reset(soft_reset[i])
    );
  end
endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed checks of routing, parity, drop, backpressure, timeout and reset.
module tb_router_1xn;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic sel = 1'b0;
  logic [2:0] rd_b = '0, rd_s = '0;
  logic [23:0] dout_b, dout_s;
  logic [2:0] vo_b, vo_s;
  logic busy_b, busy_s, err_b, err_s, drop_b, drop_s;
  logic pv_b, pv_s, cur_busy, cur_drop;
  int checks = 0, errors = 0;
  int run2 = 0, last_run2 = 0, drops = 0;
  logic [7:0] pkt[$];

  assign pv_b = pkt_valid && !sel;
  assign pv_s = pkt_valid && sel;
  assign cur_busy = sel ? busy_s : busy_b;
  assign cur_drop = sel ? drop_s : drop_b;

  router_1xn u_big (
    .clock(clock), .resetn(resetn), .pkt_valid(pv_b), .data_in(data_in), .read_enb(rd_b),
    .data_out(dout_b), .valid_out(vo_b), .busy(busy_b), .error(err_b), .dropped(drop_b)
  );
  router_1xn #(.NUM_PORTS(3), .FIFO_DEPTH(4), .TIMEOUT(30)) u_small (
    .clock(clock), .resetn(resetn), .pkt_valid(pv_s), .data_in(data_in), .read_enb(rd_s),
    .data_out(dout_s), .valid_out(vo_s), .busy(busy_s), .error(err_s), .dropped(drop_s)
  );

  always #5 clock = ~clock;

  // length of the latest run of valid_out[2] high, and total drop pulses, on the big DUT
  always @(negedge clock) begin
    if (vo_b[2]) run2++;
    else if (run2 != 0) begin
      last_run2 = run2;
      run2 = 0;
    end
    if (drop_b) drops++;
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_read(input int p);
    step;
    rd_b[p] = 1'b1;
    step;
    rd_b[p] = 1'b0;
    #3;
  endtask

  task automatic send(output logic last_drop);
    int i = 0;
    last_drop = 1'b0;
    for (int g = 0; g < 200 && i < pkt.size(); g++) begin
      step;
      pkt_valid = i != pkt.size() - 1;
      data_in = pkt[i];
      #3;
      if (!cur_busy) begin
        last_drop = cur_drop;
        i++;
      end
    end
    step;
    pkt_valid = 1'b0;
    data_in = '0;
    #3;
    checks++;
    if (i != pkt.size()) begin
      errors++;
      $display("FAIL send_accept got %0d bytes exp %0d", i, pkt.size());
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({dout_b, vo_b, busy_b, err_b, drop_b} !== '0 || {dout_s, vo_s, busy_s, err_s, drop_s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got big %h/%b/%b%b%b small %h/%b/%b%b%b exp all 0",
               dout_b, vo_b, busy_b, err_b, drop_b, dout_s, vo_s, busy_s, err_s, drop_s);
    end
    step;
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] exp [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    step;
    pkt_valid = 1'b1;
    data_in = 8'h0D;
    #3;
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy_b); end
    step;
    data_in = 8'h11;
    #3;
    checks++;
    if (busy_b !== 1'b1 || vo_b !== 3'b000) begin
      errors++;
      $display("FAIL basic_load_hdr got busy %b valid %b exp 1 000", busy_b, vo_b);
    end
    step;
    #3;
    checks++;
    if (busy_b !== 1'b0 || vo_b !== 3'b010) begin
      errors++;
      $display("FAIL basic_load_data got busy %b valid %b exp 0 010", busy_b, vo_b);
    end
    step;
    data_in = 8'h22;
    step;
    data_in = 8'h33;
    step;
    pkt_valid = 1'b0;
    data_in = 8'h0D;
    step;
    data_in = 8'h00;
    #3;
    checks++;
    if (busy_b !== 1'b1 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL basic_check got busy %b error %b exp 1 0", busy_b, err_b);
    end
    for (int i = 0; i < 5; i++) begin
      pulse_read(1);
      checks++;
      if (dout_b[15:8] !== exp[i]) begin
        errors++;
        $display("FAIL basic_data[%0d] got %h exp %h", i, dout_b[15:8], exp[i]);
      end
    end
    pulse_read(1);
    checks++;
    if (vo_b !== 3'b000 || dout_b !== 24'h000D00) begin
      errors++;
      $display("FAIL basic_after got valid %b data %h exp 000 000d00", vo_b, dout_b);
    end
  endtask

  task automatic test_error;
    logic d;
    pkt = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    send(d);
    checks++;
    if (err_b !== 1'b1 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL error_check_cycle got error %b busy %b exp 1 1", err_b, busy_b);
    end
    for (int i = 0; i < 5; i++) pulse_read(1);
    checks++;
    if (err_b !== 1'b1 || dout_b[15:8] !== 8'h0C) begin
      errors++;
      $display("FAIL error_hold got error %b data %h exp 1 0c", err_b, dout_b[15:8]);
    end
  endtask

  task automatic test_drop;
    step;
    pkt_valid = 1'b1;
    data_in = 8'h07;
    #3;
    checks++;
    if (busy_b !== 1'b0 || err_b !== 1'b1) begin
      errors++;
      $display("FAIL drop_hdr got busy %b error %b exp 0 1", busy_b, err_b);
    end
    step;
    data_in = 8'hAA;
    #3;
    checks++;
    if (busy_b !== 1'b0 || drop_b !== 1'b0 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL drop_payload got busy %b dropped %b error %b exp 0 0 0", busy_b, drop_b, err_b);
    end
    step;
    pkt_valid = 1'b0;
    data_in = 8'hAD;
    #3;
    checks++;
    if (busy_b !== 1'b0 || drop_b !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse got busy %b dropped %b exp 0 1", busy_b, drop_b);
    end
    step;
    data_in = 8'h00;
    #3;
    checks++;
    if (drop_b !== 1'b0 || vo_b !== 3'b000) begin
      errors++;
      $display("FAIL drop_after got dropped %b valid %b exp 0 000", drop_b, vo_b);
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] exp [8] = '{8'h18, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1F};
    logic [7:0] got[$];
    logic prv = 1'b0;
    int idx = 0;
    sel = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step;
      pkt_valid = idx < 7;
      data_in = idx < 8 ? exp[idx] : 8'h00;
      rd_s[0] = c >= 10;
      #3;
      if (prv) got.push_back(dout_s[7:0]);
      prv = rd_s[0] && vo_s[0];
      if (c == 9) begin
        checks++;
        if (idx != 5 || busy_s !== 1'b1 || vo_s[0] !== 1'b1) begin
          errors++;
          $display("FAIL bp_stall got accepted %0d busy %b valid %b exp 5 1 1", idx, busy_s, vo_s[0]);
        end
      end
      if (!busy_s && idx < 8) idx++;
    end
    rd_s = '0;
    sel = 1'b0;
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL bp_count got %0d bytes exp 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL bp_data[%0d] got %h exp %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (vo_s !== 3'b000 || err_s !== 1'b0) begin
      errors++;
      $display("FAIL bp_end got valid %b error %b exp 000 0", vo_s, err_s);
    end
  endtask

  task automatic test_timeout;
    logic d;
    last_run2 = 0;
    pkt = {8'h06, 8'h5A, 8'h5C};
    send(d);
    for (int c = 0; c < 60 && last_run2 == 0; c++) step;
    #3;
    checks++;
    if (last_run2 != 30 || vo_b[2] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flush got run %0d valid %b exp 30 0", last_run2, vo_b[2]);
    end
  endtask

  task automatic test_timeout_mid_packet;
    logic d;
    int d0 = drops;
    last_run2 = 0;
    pkt = {8'h52};
    for (int i = 1; i <= 20; i++) pkt.push_back(8'(i));
    pkt.push_back(8'hFF);
    send(d);
    checks++;
    if (d !== 1'b1 || drops != d0 + 1) begin
      errors++;
      $display("FAIL midpkt_drop got last %b pulses %0d exp 1 %0d", d, drops - d0, 1);
    end
    checks++;
    if (last_run2 != 30 || vo_b[2] !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_flush got run %0d valid %b busy %b exp 30 0 0", last_run2, vo_b[2], busy_b);
    end
  endtask

  task automatic test_reset_mid_packet;
    logic d;
    logic [7:0] exp [3] = '{8'h04, 8'h77, 8'h73};
    step;
    pkt_valid = 1'b1;
    data_in = 8'h0C;
    step;
    data_in = 8'h01;
    step;
    step;
    data_in = 8'h02;
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({dout_b, vo_b, busy_b, err_b, drop_b} !== '0) begin
      errors++;
      $display("FAIL reset_mid got data %h valid %b busy %b error %b dropped %b exp all 0",
               dout_b, vo_b, busy_b, err_b, drop_b);
    end
    pkt_valid = 1'b0;
    data_in = 8'h00;
    step;
    step;
    resetn = 1'b1;
    pkt = {8'h04, 8'h77, 8'h73};
    send(d);
    checks++;
    if (vo_b !== 3'b001) begin errors++; $display("FAIL reset_resume_valid got %b exp 001", vo_b); end
    for (int i = 0; i < 3; i++) begin
      pulse_read(0);
      checks++;
      if (dout_b[7:0] !== exp[i]) begin
        errors++;
        $display("FAIL reset_resume_data[%0d] got %h exp %h", i, dout_b[7:0], exp[i]);
      end
    end
    checks++;
    if (vo_b !== 3'b000 || err_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume_end got valid %b error %b exp 000 0", vo_b, err_b);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_error;
    test_drop;
    test_back_pressure;
    test_timeout;
    test_timeout_mid_packet;
    test_reset_mid_packet;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
